rom_arbiter: RTL
================

Name: rom_arbiter

Overview:
- Shares one external ROM read port (SDRAM/flash-backed image) between the mapper's PRG ROM requester (CPU side) and CHR ROM requester (PPU side).
- Sits between the mapper's promaddr/promreq/promack and cromaddr/cromreq/cromack outputs and the single memory controller port.
- Translates CHR addresses by a header-derived base.
- Arbitrates round-robin and returns read data with per-port ack pulses.

Parameters:
- AW, 22, external memory address width.
- RW, 21, requester ROM address width; must be less than AW.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset; 0 = reset.
- promaddr  in  RW  PRG ROM byte address.
- promreq  in  1  PRG request; level, held with stable address until promack.
- promdata  out  8  PRG read data; valid when promack=1 and held until the next PRG ack.
- promack  out  1  PRG completion; one-cycle pulse.
- cromaddr  in  RW  CHR ROM byte address.
- cromreq  in  1  CHR request; level.
- cromdata  out  8  CHR read data.
- cromack  out  1  CHR completion; one-cycle pulse.
- chrbase  in  AW  external base of the CHR image; quasi-static, changed only while idle.
- flush  in  1  one-cycle pulse; invalidates cached entries (only meaningful with the cache).
- memaddr  out  AW  external address.
- memreq  out  1  external request; held until memack.
- memrdata  in  8  external read data, valid with memack.
- memack  in  1  external completion; one-cycle pulse.

Behaviour:
- Reset values: memaddr=0, memreq=0, promack=0, cromack=0, promdata=0, cromdata=0, state=IDLE, last=CHR (so PRG wins the first tie), armP=armC=1.
- Arm flags:
  - A port is eligible only when req=1 and arm=1.
  - arm clears when that port's ack pulses.
  - arm sets when that port's req is sampled 0.
  - A requester holding req for one cycle past ack is therefore never served twice.
- States: IDLE, MEM, ACK.
- IDLE:
  - Neither port eligible: stay in IDLE.
  - One port eligible: grant it.
  - Both eligible: grant the port not equal to last.
  - On grant, register memaddr and set memreq=1, both on the next edge, then go to MEM.
  - PRG address = zero-extended promaddr. CHR address = chrbase + cromaddr, with cromaddr zero-extended to AW and the sum truncated to AW (wraps).
- MEM:
  - Hold memreq and memaddr.
  - On memack: capture memrdata into the granted port's data register, drop memreq, set last=granted, go to ACK.
- ACK:
  - Pulse the granted ack for exactly one cycle, then return to IDLE.
- Latency, eligible req to ack, uncached: 1 (grant/memreq) + external latency L + 1 = L+2 cycles after req is first sampled. With L=1, req sampled at edge 0 gives ack high in cycle 3.
- Back-to-back:
  - ACK→IDLE costs one cycle.
  - Continuous contention alternates P,C,P,C.
  - Neither port can starve beyond one foreign transaction.
- Requester dropping req while in MEM or ACK: the transaction still completes, ack still pulses, the requester ignores it.
- memack outside MEM is ignored.
- memack and a new req in the same cycle: the new req is considered in IDLE after ACK.
- Asynchronous reset mid-transaction: all outputs go to reset values immediately. The external controller must tolerate memreq being withdrawn.
- Data registers change only on their own port's capture, so the other port's data is stable.

Optional Feature:
- Macro: ROM_ARB_CACHE_EN.
- Enabled:
  - Each port has a one-entry cache: tag RW bits, valid, 8-bit data. The CHR tag is the untranslated cromaddr.
  - In IDLE, an eligible port whose address equals its tag and whose valid=1 is a hit. A hit skips MEM (memreq stays 0), goes to ACK next cycle with the cached data loaded into the port data register; latency 2 cycles.
  - Hits take part in round-robin like misses.
  - Every memack fill writes tag, data and valid=1.
  - flush, or reset asserted, clears both valid bits; flush during MEM also suppresses that fill's valid.
- Disabled: no cache storage; flush is ignored; every request goes through MEM.

Decomposition:
- Shared header (dat.vh): state encodings (ST_IDLE, ST_MEM, ST_ACK) and port-select constants (SEL_PRG=0, SEL_CHR=1).
- Natural sub-module: rom_arb_cache, one entry, instanced per port; compiled only under ROM_ARB_CACHE_EN.
- Arbiter FSM stays in rom_arbiter.

Test Plan:
- PRG only, promaddr=21'h00123, memory L=1 returning 8'hA5 → memaddr=22'h000123, memreq high one cycle after req, promack pulse L+2 cycles after req with promdata=A5, cromack never pulses.
- CHR only, chrbase=22'h080000, cromaddr=21'h01FFF → memaddr=22'h081FFF. With chrbase=22'h3FF000, cromaddr=21'h002000 → memaddr=22'h001000 (wrap).
- Both requesting from reset, continuously re-requesting → grant order P,C,P,C; each ack single-cycle; no ack issued while the other port's memreq is pending.
- Requester holds promreq 3 cycles past promack → exactly one memory access; re-raise after a low cycle → second access.
- Reset asserted (0) during MEM with memreq=1 → memreq, acks and data go to 0 immediately; after release, a new PRG request completes normally.
- With ROM_ARB_CACHE_EN: PRG reads 21'h00040 twice → second read has no memreq and acks in 2 cycles with the same data. flush, then a third read → memreq reissued.

Source files
------------

// File: rtl/rom_arbiter_pkg.sv
// rom_arbiter_pkg: shared definitions for the PRG/CHR ROM port arbiter.
//   state_e        : arbiter FSM states (ST_IDLE, ST_MEM, ST_ACK)
//   SEL_PRG/SEL_CHR: port-select encodings used for grant and last-served
//   rr_pick        : round-robin choice between the two eligible ports
package rom_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    localparam logic SEL_PRG = 1'b0;
    localparam logic SEL_CHR = 1'b1;

    // With both ports eligible the one not served last wins; otherwise the
    // only eligible port is chosen (CHR iff CHR alone is eligible).
    function automatic logic rr_pick(input logic elig_p, input logic elig_c,
                                     input logic last);
        return (elig_p && elig_c) ? ~last : elig_c;
    endfunction

endpackage

// File: rtl/rom_arb_cache.sv
// rom_arb_cache: one-entry read cache for a single ROM requester port.
// Only compiled into the design when ROM_ARB_CACHE_EN is defined.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset (clears entry)
//   flush_i           : clears the valid bit
//   lookup_addr_i     : requester address to compare against the tag
//   hit_o, rd_data_o  : entry valid and tag match; cached byte
//   fill_i            : write tag/data from a completed memory read
//   fill_tag_i        : tag written on fill
//   fill_data_i       : data written on fill
//   fill_inhibit_i    : a flush arrived during the fill's memory access
import rom_arbiter_pkg::*;

module rom_arb_cache #(
    parameter int RW = 21
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush_i,
    input  logic [RW-1:0] lookup_addr_i,
    output logic          hit_o,
    output logic [7:0]    rd_data_o,
    input  logic          fill_i,
    input  logic [RW-1:0] fill_tag_i,
    input  logic [7:0]    fill_data_i,
    input  logic          fill_inhibit_i
);

    logic [RW-1:0] tag_q;
    logic [7:0]    data_q;
    logic          valid_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (fill_i) begin
            tag_q   <= fill_tag_i;
            data_q  <= fill_data_i;
            // A flush seen at any point of this access leaves the entry invalid.
            valid_q <= !(flush_i || fill_inhibit_i);
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end
    end

    assign hit_o     = valid_q && (lookup_addr_i == tag_q);
    assign rd_data_o = data_q;

endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one external ROM read port between the mapper's PRG
// (CPU side) and CHR (PPU side) requesters, round-robin, with per-port ack
// pulses. CHR addresses are offset by chrbase (sum wraps at AW bits).
// Optional feature: define ROM_ARB_CACHE_EN for a one-entry cache per port.
// Ports:
//   clk, reset                 : clock, asynchronous active-low reset
//   promaddr/promreq           : PRG request (level, address stable until ack)
//   promdata/promack           : PRG read data (held) and one-cycle ack
//   cromaddr/cromreq           : CHR request
//   cromdata/cromack           : CHR read data and one-cycle ack
//   chrbase                    : external base of the CHR image
//   flush                      : invalidates cache entries (cache build only)
//   memaddr/memreq             : external request, held until memack
//   memrdata/memack            : external read data and completion pulse
import rom_arbiter_pkg::*;

module rom_arbiter #(
    parameter int AW = 22,
    parameter int RW = 21
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [RW-1:0] promaddr,
    input  logic          promreq,
    output logic [7:0]    promdata,
    output logic          promack,
    input  logic [RW-1:0] cromaddr,
    input  logic          cromreq,
    output logic [7:0]    cromdata,
    output logic          cromack,
    input  logic [AW-1:0] chrbase,
    input  logic          flush,
    output logic [AW-1:0] memaddr,
    output logic          memreq,
    input  logic [7:0]    memrdata,
    input  logic          memack
);

    state_e        state_q;
    logic          sel_q, last_q;
    logic          armp_q, armc_q;
    logic [AW-1:0] memaddr_q;
    logic          memreq_q;
    logic          promack_q, cromack_q;
    logic [7:0]    promdata_q, cromdata_q;

    logic          elig_p, elig_c, sel_d;
    logic [AW-1:0] memaddr_d;
    logic          xfer_done;
    logic [7:0]    xfer_data;

    assign elig_p    = promreq && armp_q;
    assign elig_c    = cromreq && armc_q;
    assign sel_d     = rr_pick(elig_p, elig_c, last_q);
    assign memaddr_d = (sel_d == SEL_CHR) ? chrbase + {{(AW-RW){1'b0}}, cromaddr}
                                          : {{(AW-RW){1'b0}}, promaddr};

`ifdef ROM_ARB_CACHE_EN
    logic          hit_q, flush_mem_q;
    logic [RW-1:0] rqaddr_q;
    logic          hit_p, hit_c, fill_p, fill_c, hit_d;
    logic [7:0]    cdata_p, cdata_c;

    assign hit_d  = (sel_d == SEL_CHR) ? hit_c : hit_p;
    assign fill_p = (state_q == ST_MEM) && !hit_q && memack && (sel_q == SEL_PRG);
    assign fill_c = (state_q == ST_MEM) && !hit_q && memack && (sel_q == SEL_CHR);

    // CHR entries are tagged with the untranslated cromaddr.
    rom_arb_cache #(.RW(RW)) u_cache_p (
        .clk(clk), .reset(reset), .flush_i(flush),
        .lookup_addr_i(promaddr), .hit_o(hit_p), .rd_data_o(cdata_p),
        .fill_i(fill_p), .fill_tag_i(rqaddr_q), .fill_data_i(memrdata),
        .fill_inhibit_i(flush_mem_q)
    );

    rom_arb_cache #(.RW(RW)) u_cache_c (
        .clk(clk), .reset(reset), .flush_i(flush),
        .lookup_addr_i(cromaddr), .hit_o(hit_c), .rd_data_o(cdata_c),
        .fill_i(fill_c), .fill_tag_i(rqaddr_q), .fill_data_i(memrdata),
        .fill_inhibit_i(flush_mem_q)
    );

    // A hit spends its MEM cycle without touching memory, giving ack at 2 cycles.
    assign xfer_done = hit_q || memack;
    assign xfer_data = hit_q ? ((sel_q == SEL_CHR) ? cdata_c : cdata_p) : memrdata;
`else
    logic unused_flush;
    assign unused_flush = flush;

    assign xfer_done = memack;
    assign xfer_data = memrdata;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            sel_q      <= SEL_PRG;
            last_q     <= SEL_CHR;
            armp_q     <= 1'b1;
            armc_q     <= 1'b1;
            memaddr_q  <= '0;
            memreq_q   <= 1'b0;
            promack_q  <= 1'b0;
            cromack_q  <= 1'b0;
            promdata_q <= '0;
            cromdata_q <= '0;
`ifdef ROM_ARB_CACHE_EN
            hit_q       <= 1'b0;
            flush_mem_q <= 1'b0;
            rqaddr_q    <= '0;
`endif
        end else begin
            promack_q <= 1'b0;
            cromack_q <= 1'b0;
            // A low request re-arms even in the ack cycle: the requester has
            // already let go, so it cannot be served twice.
            armp_q <= !promreq ? 1'b1 : (promack_q ? 1'b0 : armp_q);
            armc_q <= !cromreq ? 1'b1 : (cromack_q ? 1'b0 : armc_q);

            case (state_q)
                ST_IDLE: begin
                    if (elig_p || elig_c) begin
                        sel_q   <= sel_d;
                        state_q <= ST_MEM;
`ifdef ROM_ARB_CACHE_EN
                        rqaddr_q    <= (sel_d == SEL_CHR) ? cromaddr : promaddr;
                        flush_mem_q <= 1'b0;
                        if (hit_d) begin
                            hit_q <= 1'b1;
                        end else begin
                            memreq_q  <= 1'b1;
                            memaddr_q <= memaddr_d;
                        end
`else
                        memreq_q  <= 1'b1;
                        memaddr_q <= memaddr_d;
`endif
                    end
                end
                ST_MEM: begin
`ifdef ROM_ARB_CACHE_EN
                    if (flush) flush_mem_q <= 1'b1;
`endif
                    if (xfer_done) begin
`ifdef ROM_ARB_CACHE_EN
                        hit_q <= 1'b0;
`endif
                        memreq_q <= 1'b0;
                        last_q   <= sel_q;
                        state_q  <= ST_ACK;
                        if (sel_q == SEL_CHR) begin
                            cromdata_q <= xfer_data;
                            cromack_q  <= 1'b1;
                        end else begin
                            promdata_q <= xfer_data;
                            promack_q  <= 1'b1;
                        end
                    end
                end
                ST_ACK:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign memaddr  = memaddr_q;
    assign memreq   = memreq_q;
    assign promack  = promack_q;
    assign cromack  = cromack_q;
    assign promdata = promdata_q;
    assign cromdata = cromdata_q;

endmodule
